// File: rtl/register_file.sv
// Multi-port register file with per-byte write enables, same-cycle write bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module register_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [WIDTH/8-1:0]  wbe,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic [ADDR_W-1:0]   raddr_a,
  output logic [WIDTH-1:0]    rdata_a,
  output logic                busy_a,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic [WIDTH-1:0]    rdata_b,
  output logic                busy_b
);

  localparam int unsigned NumBytes = WIDTH / 8;

  logic [WIDTH-1:0]  memQ [DEPTH];
  logic [DEPTH-1:0]  busyQ;
  logic [WIDTH-1:0]  byteMask;
  logic              writeValid;
  logic              issueValid;
  logic [ADDR_W-1:0] raddr [2];
  logic [WIDTH-1:0]  rdata [2];
  logic              busy  [2];

  // In range and not the hardwired zero register.
  function automatic logic addrValid(input logic [ADDR_W-1:0] addr);
    return (32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0));
  endfunction

  always_comb begin
    byteMask = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      byteMask[8*i +: 8] = {8{wbe[i]}};
    end
  end

  assign writeValid = we && addrValid(waddr);
  assign issueValid = issue_en && addrValid(issue_addr);

  // Issue is applied after writeback so a same-edge new producer keeps the register busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        memQ[i] <= '0;
      end
      busyQ <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        memQ[i] <= '0;
      end
      busyQ <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (writeValid && (waddr == ADDR_W'(i))) begin
          memQ[i]  <= (memQ[i] & ~byteMask) | (wdata & byteMask);
          busyQ[i] <= 1'b0;
        end
        if (issueValid && (issue_addr == ADDR_W'(i))) begin
          busyQ[i] <= 1'b1;
        end
      end
    end
  end

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  // Bypass stays live during clr but is suppressed while reset is held.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      busy[p]  = 1'b0;
      if (!reset && addrValid(raddr[p])) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (raddr[p] == ADDR_W'(i)) begin
            rdata[p] = memQ[i];
            busy[p]  = busyQ[i];
          end
        end
        if (writeValid && (waddr == raddr[p])) begin
          rdata[p] = (rdata[p] & ~byteMask) | (wdata & byteMask);
          busy[p]  = 1'b0;
        end
      end
    end
  end

  assign rdata_a = rdata[0];
  assign busy_a  = busy[0];
  assign rdata_b = rdata[1];
  assign busy_b  = busy[1];

endmodule
